// File: rtl/writeback_stage_if.sv
// MEM/WB writeback bus: MEM-stage payload in, register-file write port and
// ID-stage bypass out. The master side is the surrounding pipeline; the
// slave side is the writeback stage itself.
interface writeback_stage_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic                  in_reg_write;
    logic                  in_mem_to_reg;
    logic                  in_link;
    logic [REG_ADDR_W-1:0] in_write_reg;
    logic [DATA_W-1:0]     in_alu_result;
    logic [DATA_W-1:0]     in_mem_data;
    logic [DATA_W-1:0]     in_pc_plus1;
    logic [REG_ADDR_W-1:0] id_read_reg_1;
    logic [REG_ADDR_W-1:0] id_read_reg_2;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     reg_file_write_data;
    logic                  RegWrite;
    logic                  fwd_sel_1;
    logic                  fwd_sel_2;
    logic [DATA_W-1:0]     fwd_data;
    logic [CNT_W-1:0]      wb_count;

    modport master (
        output stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_link,
               in_write_reg, in_alu_result, in_mem_data, in_pc_plus1,
               id_read_reg_1, id_read_reg_2,
        input  write_reg, reg_file_write_data, RegWrite,
               fwd_sel_1, fwd_sel_2, fwd_data, wb_count
    );

    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_link,
               in_write_reg, in_alu_result, in_mem_data, in_pc_plus1,
               id_read_reg_1, id_read_reg_2,
        output write_reg, reg_file_write_data, RegWrite,
               fwd_sel_1, fwd_sel_2, fwd_data, wb_count
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with result select for the 16-bit MIPS.
// Drives the register-file write port, provides same-cycle bypass to decode
// (the register file commits on the edge while decode reads combinationally)
// and counts retired register writes.
module writeback_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int LINK_REG   = 7,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  wb
);
    localparam logic [REG_ADDR_W-1:0] LP_LINK = REG_ADDR_W'(LINK_REG);
    localparam logic [CNT_W-1:0]      LP_ONE  = CNT_W'(1);

    logic                  r_valid;
    logic                  r_reg_write;
    logic                  r_mem_to_reg;
    logic                  r_link;
    logic [REG_ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0]     r_alu;
    logic [DATA_W-1:0]     r_mem;
    logic [DATA_W-1:0]     r_pc1;
    logic                  r_done;
    logic [CNT_W-1:0]      r_count;

    logic [REG_ADDR_W-1:0] w_dest;
    logic [DATA_W-1:0]     w_data;
    logic                  w_reg_write;
    logic [REG_ADDR_W-1:0] w_write_reg;
    logic [DATA_W-1:0]     w_write_data;

    // Stage register: reset, flush to bubble, hold under stall, else load.
    // r_done remembers that a held instruction already wrote, so a stalled
    // instruction commits exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_link       <= 1'b0;
            r_write_reg  <= '0;
            r_alu        <= '0;
            r_mem        <= '0;
            r_pc1        <= '0;
            r_done       <= 1'b0;
        end else if (wb.flush) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (wb.stall) begin
            r_done <= r_done | w_reg_write;
        end else begin
            r_valid      <= wb.in_valid;
            r_reg_write  <= wb.in_reg_write;
            r_mem_to_reg <= wb.in_mem_to_reg;
            r_link       <= wb.in_link;
            r_write_reg  <= wb.in_write_reg;
            r_alu        <= wb.in_alu_result;
            r_mem        <= wb.in_mem_data;
            r_pc1        <= wb.in_pc_plus1;
            r_done       <= 1'b0;
        end
    end

    // Retired-write counter; survives flush, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_reg_write) begin
            r_count <= r_count + LP_ONE;
        end
    end

    // Destination/data select, write enable (r0 never written) and bypass.
    always_comb begin
        w_dest       = r_link ? LP_LINK : r_write_reg;
        w_data       = r_link ? r_pc1 : (r_mem_to_reg ? r_mem : r_alu);
        w_reg_write  = r_valid & r_reg_write & ~r_done & (w_dest != '0);
        w_write_reg  = r_valid ? w_dest : '0;
        w_write_data = r_valid ? w_data : '0;
    end

    assign wb.write_reg           = w_write_reg;
    assign wb.reg_file_write_data = w_write_data;
    assign wb.RegWrite            = w_reg_write;
    assign wb.fwd_sel_1           = w_reg_write & (w_write_reg == wb.id_read_reg_1);
    assign wb.fwd_sel_2           = w_reg_write & (w_write_reg == wb.id_read_reg_2);
    assign wb.fwd_data            = w_write_data;
    assign wb.wb_count            = r_count;
endmodule
